// File: rtl/canon_huff_builder.sv
// canon_huff_builder: canonical Huffman table builder for the DEFLATE decoder.
// Latency: start -> done = 1 + NSYM + MAXLEN*NSYM cycles when len_valid stays high.
// Backpressure: len_ready is high only in LOAD, and len_valid low stalls the load.
//
// Optional build macro: CHB_KRAFT_CHECK_EN adds the over-subscription (Kraft) check
// that drives err. Without it, err is tied low and no check logic is built.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   start                begin a new build; honoured only in IDLE or DONE
//   len_valid/len_ready  code-length handshake; len_data = length of next symbol
//   busy                 high in LOAD and SORT
//   done                 one-cycle pulse on DONE entry
//   tables_valid         high in DONE until the next start or reset
//   count_sq             count per length 1..MAXLEN, length 1 in the LSBs
//   first_code_sq        first canonical code per length, length 1 in the LSBs
//   nnz                  number of symbols with a nonzero length
//   rd_rank -> rd_sym    combinational read of the rank-ordered symbol table
//   err                  over-subscribed length set (Kraft check builds only)
module canon_huff_builder #(
    parameter int NSYM = 19,
    parameter int LW   = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic                                        len_valid,
    output logic                                        len_ready,
    input  logic [LW-1:0]                               len_data,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        tables_valid,
    output logic [((1<<LW)-1)*$clog2(NSYM+1)-1:0]       count_sq,
    output logic [((1<<LW)-1)*((1<<LW)-1)-1:0]          first_code_sq,
    output logic [$clog2(NSYM+1)-1:0]                   nnz,
    input  logic [$clog2(NSYM)-1:0]                     rd_rank,
    output logic [$clog2(NSYM)-1:0]                     rd_sym,
    output logic                                        err
);

    localparam int MAXLEN = (1 << LW) - 1;
    localparam int SW     = $clog2(NSYM);
    localparam int CW     = $clog2(NSYM + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SORT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Stored tables
    logic [LW-1:0]     lens_q   [0:NSYM-1];
    logic [CW-1:0]     count_q  [1:MAXLEN];
    logic [MAXLEN-1:0] first_q  [1:MAXLEN];
    logic [SW-1:0]     sorted_q [0:NSYM-1];
    logic [CW-1:0]     nnz_q;
    logic              done_q;

    // Load and scan counters
    logic [SW-1:0]     idx_q;
    logic [LW-1:0]     len_q;
    logic [SW-1:0]     pos_q;
    logic [SW-1:0]     rank_q;
    logic [MAXLEN-1:0] code_q;

    // Decodes
    logic              start_ok;
    logic              hs;
    logic              load_last;
    logic              pos_last;
    logic              len_last;
    logic              sort_len_end;
    logic [MAXLEN-1:0] cnt_ext;
    logic [MAXLEN-1:0] code_sum;
    logic [MAXLEN-1:0] code_nxt;

    assign start_ok     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign len_ready    = (state_q == S_LOAD);
    assign hs           = len_valid && len_ready;
    assign load_last    = hs && (idx_q == SW'(NSYM - 1));
    assign pos_last     = (pos_q == SW'(NSYM - 1));
    assign len_last     = (len_q == LW'(MAXLEN));
    assign sort_len_end = (state_q == S_SORT) && pos_last;

    // Next first code: (code + count[len]) << 1, all modulo 2^MAXLEN.
    assign cnt_ext  = MAXLEN'(count_q[len_q]);
    assign code_sum = code_q + cnt_ext;
    assign code_nxt = code_sum << 1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (load_last) state_d = S_SORT;
            end
            S_SORT: begin
                if (pos_last && len_last) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Reset and an accepted start clear the same state, so a
    // new build never sees residue from the previous one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            for (int s = 0; s < NSYM; s++) begin
                lens_q[s]   <= '0;
                sorted_q[s] <= '0;
            end
            for (int l = 1; l <= MAXLEN; l++) begin
                count_q[l] <= '0;
                first_q[l] <= '0;
            end
            nnz_q  <= '0;
            done_q <= 1'b0;
            idx_q  <= '0;
            len_q  <= LW'(1);
            pos_q  <= '0;
            rank_q <= '0;
            code_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (hs) begin
                        lens_q[idx_q] <= len_data;
                        idx_q         <= idx_q + SW'(1);
                        if (len_data != '0) begin
                            count_q[len_data] <= count_q[len_data] + CW'(1);
                            nnz_q             <= nnz_q + CW'(1);
                        end
                    end
                end
                S_SORT: begin
                    // Scanning symbols in ascending order within each length
                    // gives canonical tie ordering for free.
                    if (lens_q[pos_q] == len_q) begin
                        sorted_q[rank_q] <= pos_q;
                        rank_q           <= rank_q + SW'(1);
                    end
                    if (pos_last) begin
                        pos_q  <= '0;
                        code_q <= code_nxt;
                        // first_q[1] is never written and stays 0.
                        if (!len_last) begin
                            first_q[len_q + LW'(1)] <= code_nxt;
                            len_q                   <= len_q + LW'(1);
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else begin
                        pos_q <= pos_q + SW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional Kraft over-subscription check
    // ------------------------------------------------------------------
`ifdef CHB_KRAFT_CHECK_EN
    // 'left' is the number of unused codes at the current length. It never
    // exceeds 2^MAXLEN before going negative, and it is frozen once negative,
    // so this width cannot overflow.
    localparam int KW = MAXLEN + CW + 2;

    logic signed [KW-1:0] left_q;
    logic signed [KW-1:0] left_nxt;
    logic                 err_q;

    assign left_nxt = (left_q <<< 1) - $signed(KW'(count_q[len_q]));

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            left_q <= {{(KW-1){1'b0}}, 1'b1};
            err_q  <= 1'b0;
        end else if (sort_len_end && !err_q) begin
            left_q <= left_nxt;
            if (left_nxt[KW-1]) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy         = (state_q == S_LOAD) || (state_q == S_SORT);
    assign done         = done_q;
    assign tables_valid = (state_q == S_DONE);
    assign nnz          = nnz_q;

    always_comb begin
        count_sq      = '0;
        first_code_sq = '0;
        for (int l = 1; l <= MAXLEN; l++) begin
            count_sq[(l-1)*CW +: CW]               = count_q[l];
            first_code_sq[(l-1)*MAXLEN +: MAXLEN]  = first_q[l];
        end
    end

    // Ranks at or above nnz hold the cleared value 0. Out-of-range ranks also
    // read 0 because the table is shorter than 2^SW.
    assign rd_sym = ({1'b0, rd_rank} < (SW+1)'(NSYM)) ? sorted_q[rd_rank] : '0;

endmodule

// File: tb/tb_canon_huff_builder.sv
// Testbench for canon_huff_builder: randomized and directed builds checked by a scoreboard.
// Builds are checked when the done pulse appears, including the cycle on which it arrives.
// Stimulus inserts len_valid stalls to exercise LOAD backpressure.
module tb_canon_huff_builder;

    localparam int NSYM   = 19;
    localparam int LW     = 3;
    localparam int MAXLEN = (1 << LW) - 1;
    localparam int SW     = $clog2(NSYM);
    localparam int CW     = $clog2(NSYM + 1);
    localparam int BUILD  = 1 + NSYM + MAXLEN * NSYM;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic                     len_valid;
    logic                     len_ready;
    logic [LW-1:0]            len_data;
    logic                     busy;
    logic                     done;
    logic                     tables_valid;
    logic [MAXLEN*CW-1:0]     count_sq;
    logic [MAXLEN*MAXLEN-1:0] first_code_sq;
    logic [CW-1:0]            nnz;
    logic [SW-1:0]            rd_rank;
    logic [SW-1:0]            rd_sym;
    logic                     err;

    canon_huff_builder #(.NSYM(NSYM), .LW(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len_valid    (len_valid),
        .len_ready    (len_ready),
        .len_data     (len_data),
        .busy         (busy),
        .done         (done),
        .tables_valid (tables_valid),
        .count_sq     (count_sq),
        .first_code_sq(first_code_sq),
        .nnz          (nnz),
        .rd_rank      (rd_rank),
        .rd_sym       (rd_sym),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cnt [1:MAXLEN];
        int fc  [1:MAXLEN];
        int srt [0:NSYM-1];
        int nz;
        int er;
        int dcyc;
    } exp_t;

    exp_t sbq[$];
    int   cur_lens [0:NSYM-1];
    int   checks = 0;
    int   errors = 0;
    int   seen   = 0;
    int   builds = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Reference model: counting, the DEFLATE bl_count recurrence, rank by
    // pairwise (length, symbol) comparison, and a Kraft-sum test.
    function automatic exp_t model(input int dcyc);
        exp_t e;
        int   code;
        int   ks;
        int   r;
        for (int l = 1; l <= MAXLEN; l++) e.cnt[l] = 0;
        e.nz = 0;
        for (int s = 0; s < NSYM; s++) begin
            if (cur_lens[s] != 0) begin
                e.cnt[cur_lens[s]]++;
                e.nz++;
            end
        end
        code    = 0;
        e.fc[1] = 0;
        for (int b = 2; b <= MAXLEN; b++) begin
            code    = ((code + e.cnt[b-1]) << 1) % (1 << MAXLEN);
            e.fc[b] = code;
        end
        for (int s = 0; s < NSYM; s++) e.srt[s] = 0;
        for (int s = 0; s < NSYM; s++) begin
            if (cur_lens[s] != 0) begin
                r = 0;
                for (int t = 0; t < NSYM; t++) begin
                    if (cur_lens[t] != 0 &&
                        (cur_lens[t] < cur_lens[s] || (cur_lens[t] == cur_lens[s] && t < s)))
                        r++;
                end
                e.srt[r] = s;
            end
        end
        ks = 0;
        for (int s = 0; s < NSYM; s++)
            if (cur_lens[s] != 0) ks += 1 << (MAXLEN - cur_lens[s]);
`ifdef CHB_KRAFT_CHECK_EN
        e.er = (ks > (1 << MAXLEN)) ? 1 : 0;
`else
        e.er = 0;
`endif
        e.dcyc = dcyc;
        return e;
    endfunction

    // Monitor: pops an expectation on every done pulse.
    initial begin : monitor
        exp_t e;
        rd_rank = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done seen at cycle %0d, none expected", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.dcyc);
                    chk("tables_valid", tables_valid, 1);
                    chk("busy_in_done", busy, 0);
                    chk("nnz", nnz, e.nz);
                    chk("err", err, e.er);
                    for (int l = 1; l <= MAXLEN; l++) begin
                        chk($sformatf("count[%0d]", l), count_sq[(l-1)*CW +: CW], e.cnt[l]);
                        chk($sformatf("first_code[%0d]", l),
                            first_code_sq[(l-1)*MAXLEN +: MAXLEN], e.fc[l]);
                    end
                    for (int r = 0; r < NSYM; r++) begin
                        rd_rank = SW'(r);
                        #1;
                        chk($sformatf("rd_sym[%0d]", r), rd_sym, e.srt[r]);
                    end
                    @(negedge clk);
                    chk("done_pulse_width", done, 0);
                    seen++;
                end
            end
        end
    end

    task automatic check_reset_vals(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_len_ready"}, len_ready, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_tables_valid"}, tables_valid, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_nnz"}, nnz, 0);
        chk({p, "_count_sq"}, count_sq, 0);
        chk({p, "_first_code_sq"}, first_code_sq, 0);
        chk({p, "_rd_sym"}, rd_sym, 0);
    endtask

    // Called at posedge+1 in the first LOAD cycle.
    task automatic feed(input int stall_at, input int stall_n, input int pulse_at);
        for (int i = 0; i < NSYM; i++) begin
            if (i == stall_at && stall_n > 0) begin
                len_valid = 1'b0;
                repeat (stall_n) @(posedge clk);
                #1;
            end
            len_valid = 1'b1;
            len_data  = LW'(cur_lens[i]);
            if (i == pulse_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        len_valid = 1'b0;
    endtask

    task automatic wait_seen(input int n);
        int g;
        g = 0;
        while (seen < n && g < 600) begin
            @(negedge clk);
            g++;
        end
        chk("scoreboard_drain", seen, n);
        @(posedge clk);
        #1;
    endtask

    task automatic do_build(input int stall_at, input int stall_n, input int pulse_at);
        int t;
        start = 1'b1;
        t     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("clr_tables_valid", tables_valid, 0);
        chk("clr_nnz", nnz, 0);
        chk("clr_count_sq", count_sq, 0);
        chk("clr_first_code_sq", first_code_sq, 0);
        chk("clr_err", err, 0);
        chk("clr_rd_sym", rd_sym, 0);
        chk("load_busy", busy, 1);
        chk("load_len_ready", len_ready, 1);
        sbq.push_back(model(t + BUILD + stall_n));
        builds++;
        feed(stall_at, stall_n, pulse_at);
        wait_seen(builds);
    endtask

    task automatic set_nominal();
        for (int s = 0; s < NSYM; s++) cur_lens[s] = 0;
        cur_lens[0] = 2;
        cur_lens[1] = 1;
        cur_lens[2] = 3;
        cur_lens[3] = 3;
    endtask

    initial begin : stim
        int t;
        rst_n     = 1'b0;
        start     = 1'b0;
        len_valid = 1'b0;
        len_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_vals("reset");

        // Nominal build
        set_nominal();
        do_build(-1, 0, -1);

        // Same lengths with a 5-cycle gap mid-stream
        do_build(9, 5, -1);

        // Over-subscribed: every symbol length 1
        for (int s = 0; s < NSYM; s++) cur_lens[s] = 1;
        do_build(-1, 0, -1);

        // All-zero lengths
        for (int s = 0; s < NSYM; s++) cur_lens[s] = 0;
        do_build(-1, 0, -1);

        // Reset mid-SORT, with start asserted alongside the reset
        set_nominal();
        start = 1'b1;
        t     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        feed(-1, 0, -1);
        while (cyc < t + 60) begin
            @(posedge clk);
            #1;
        end
        chk("busy_mid_sort", busy, 1);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        check_reset_vals("mid_sort_reset");
        @(posedge clk);
        #1;
        chk("reset_beats_start", busy, 0);
        do_build(-1, 0, -1);

        // Restart from DONE, with a start pulse inside LOAD that must be ignored
        for (int s = 0; s < NSYM; s++) cur_lens[s] = $urandom_range(0, MAXLEN);
        do_build(-1, 0, 7);

        // Randomized builds with random stalls
        repeat (8) begin
            for (int s = 0; s < NSYM; s++)
                cur_lens[s] = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, MAXLEN);
            do_build($urandom_range(0, NSYM - 1), $urandom_range(0, 4), -1);
        end

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
